// File: rtl/xmodem_imem_loader_pkg.sv
// Shared XMODEM protocol constants, loader state encoding and checksum helper.
package xmodem_imem_loader_pkg;

    localparam logic [7:0] SOH         = 8'h01;
    localparam logic [7:0] EOT         = 8'h04;
    localparam logic [7:0] ACK         = 8'h06;
    localparam logic [7:0] NAK         = 8'h15;
    localparam int         BLOCK_BYTES = 128;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BLK   = 3'd1,
        BLKN  = 3'd2,
        DATA  = 3'd3,
        CKSUM = 3'd4,
        RESP  = 3'd5,
        DONE  = 3'd6
    } state_t;

    // Running modulo-256 checksum used by XMODEM (plain byte sum, carries dropped).
    function automatic logic [7:0] cksum_add(input logic [7:0] sum, input logic [7:0] data);
        return sum + data;
    endfunction

endpackage

// File: rtl/xmodem_imem_loader_if.sv
// UART FIFO handshake, instruction-memory write port and status of the loader.
interface xmodem_imem_loader_if #(
    parameter int NB_UART_DATA    = 8,
    parameter int NB_INSTRUCTION  = 32,
    parameter int IMEM_ADDR_WIDTH = 6
) ();

    logic                       i_en;
    logic [NB_UART_DATA-1:0]    i_uart_rx_data;
    logic                       i_uart_rx_empty;
    logic                       o_uart_rd;
    logic                       i_uart_tx_full;
    logic                       o_uart_wr;
    logic [NB_UART_DATA-1:0]    o_uart_wdata;
    logic                       o_uart_tx_start;
    logic                       o_imem_wr_en;
    logic [IMEM_ADDR_WIDTH-1:0] o_imem_addr;
    logic [NB_INSTRUCTION-1:0]  o_imem_wdata;
    logic                       o_busy;
    logic                       o_load_done;

    // Loader side.
    modport master (
        input  i_en, i_uart_rx_data, i_uart_rx_empty, i_uart_tx_full,
        output o_uart_rd, o_uart_wr, o_uart_wdata, o_uart_tx_start,
        output o_imem_wr_en, o_imem_addr, o_imem_wdata, o_busy, o_load_done
    );

    // UART / memory / controller side.
    modport slave (
        output i_en, i_uart_rx_data, i_uart_rx_empty, i_uart_tx_full,
        input  o_uart_rd, o_uart_wr, o_uart_wdata, o_uart_tx_start,
        input  o_imem_wr_en, o_imem_addr, o_imem_wdata, o_busy, o_load_done
    );

endinterface

// File: rtl/xmodem_imem_loader.sv
// XMODEM (checksum variant) receiver that streams 128-byte blocks from the UART
// RX FIFO into instruction memory, packing bytes little-endian into words and
// answering each block with ACK/NAK through the UART TX FIFO.
module xmodem_imem_loader
    import xmodem_imem_loader_pkg::*;
#(
    parameter int NB_UART_DATA    = 8,
    parameter int NB_INSTRUCTION  = 32,
    parameter int IMEM_ADDR_WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 i_rst_n,
    xmodem_imem_loader_if.master bus
);

    state_t                     state_r;
    logic [7:0]                 expected_r;
    logic [7:0]                 blk_r;
    logic [7:0]                 cksum_r;
    logic [7:0]                 resp_r;
    logic [6:0]                 cnt_r;
    logic [23:0]                word_r;
    logic [IMEM_ADDR_WIDTH-1:0] addr_r;
    logic                       wr_blk_r;
    logic                       ack_ok_r;
    logic                       eot_r;
    logic                       resp_phase_r;

    logic                       imem_wr_en_r;
    logic [IMEM_ADDR_WIDTH-1:0] imem_addr_r;
    logic [NB_INSTRUCTION-1:0]  imem_wdata_r;
    logic                       uart_wr_r;
    logic [NB_UART_DATA-1:0]    uart_wdata_r;
    logic                       tx_start_r;

    logic                       pop_s;
    logic [7:0]                 rx_byte_s;
    logic                       valid_s;
    logic                       new_s;
    logic                       dup_s;
    logic [7:0]                 exp_m1_s;
    logic [IMEM_ADDR_WIDTH-1:0] base_addr_s;

    assign rx_byte_s   = bus.i_uart_rx_data;
    assign valid_s     = ((blk_r ^ rx_byte_s) == 8'hFF);
    assign new_s       = (blk_r == expected_r);
    assign exp_m1_s    = expected_r - 8'd1;
    assign dup_s       = (blk_r == exp_m1_s);
    // Each block holds 32 words, so block n starts at word (n-1)*32, wrapped to the memory size.
    assign base_addr_s = IMEM_ADDR_WIDTH'({exp_m1_s, 5'd0});

    // Pop the RX FIFO head in the same cycle it is consumed, only in byte-accepting states.
    always_comb begin
        pop_s = 1'b0;
        case (state_r)
            IDLE, BLK, BLKN, DATA, CKSUM: pop_s = bus.i_en & ~bus.i_uart_rx_empty;
            default:                      pop_s = 1'b0;
        endcase
    end

    // Protocol FSM with block datapath and registered strobes; i_en low freezes everything.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r      <= IDLE;
            expected_r   <= 8'h01;
            blk_r        <= 8'h00;
            cksum_r      <= 8'h00;
            resp_r       <= 8'h00;
            cnt_r        <= 7'd0;
            word_r       <= 24'd0;
            addr_r       <= '0;
            wr_blk_r     <= 1'b0;
            ack_ok_r     <= 1'b0;
            eot_r        <= 1'b0;
            resp_phase_r <= 1'b0;
            imem_wr_en_r <= 1'b0;
            imem_addr_r  <= '0;
            imem_wdata_r <= '0;
            uart_wr_r    <= 1'b0;
            uart_wdata_r <= '0;
            tx_start_r   <= 1'b0;
        end else begin
            imem_wr_en_r <= 1'b0;
            uart_wr_r    <= 1'b0;
            tx_start_r   <= 1'b0;
            if (bus.i_en) begin
                case (state_r)
                    IDLE: begin
                        if (pop_s && rx_byte_s == SOH) begin
                            state_r <= BLK;
                        end else if (pop_s && rx_byte_s == EOT) begin
                            resp_r       <= ACK;
                            eot_r        <= 1'b1;
                            resp_phase_r <= 1'b0;
                            state_r      <= RESP;
                        end
                    end
                    BLK: begin
                        if (pop_s) begin
                            blk_r   <= rx_byte_s;
                            state_r <= BLKN;
                        end
                    end
                    BLKN: begin
                        if (pop_s) begin
                            cnt_r    <= 7'd0;
                            cksum_r  <= 8'h00;
                            word_r   <= 24'd0;
                            wr_blk_r <= valid_s & new_s;
                            ack_ok_r <= valid_s & (new_s | dup_s);
                            addr_r   <= base_addr_s;
                            state_r  <= DATA;
                        end
                    end
                    DATA: begin
                        if (pop_s) begin
                            cksum_r <= cksum_add(cksum_r, rx_byte_s);
                            case (cnt_r[1:0])
                                2'd0: word_r[7:0]   <= rx_byte_s;
                                2'd1: word_r[15:8]  <= rx_byte_s;
                                2'd2: word_r[23:16] <= rx_byte_s;
                                2'd3: begin
                                    if (wr_blk_r) begin
                                        imem_wr_en_r <= 1'b1;
                                        imem_addr_r  <= addr_r;
                                        imem_wdata_r <= {rx_byte_s, word_r};
                                        addr_r       <= addr_r + 1'b1;
                                    end
                                end
                                default: word_r <= word_r;
                            endcase
                            cnt_r <= cnt_r + 7'd1;
                            if (cnt_r == 7'(BLOCK_BYTES - 1)) begin
                                state_r <= CKSUM;
                            end
                        end
                    end
                    CKSUM: begin
                        if (pop_s) begin
                            if (ack_ok_r && rx_byte_s == cksum_r) begin
                                resp_r <= ACK;
                                if (wr_blk_r) begin
                                    expected_r <= expected_r + 8'd1;
                                end
                            end else begin
                                resp_r <= NAK;
                            end
                            eot_r        <= 1'b0;
                            resp_phase_r <= 1'b0;
                            state_r      <= RESP;
                        end
                    end
                    RESP: begin
                        if (!resp_phase_r) begin
                            if (!bus.i_uart_tx_full) begin
                                uart_wr_r    <= 1'b1;
                                uart_wdata_r <= resp_r;
                                resp_phase_r <= 1'b1;
                            end
                        end else begin
                            tx_start_r   <= 1'b1;
                            resp_phase_r <= 1'b0;
                            state_r      <= eot_r ? DONE : IDLE;
                        end
                    end
                    DONE: state_r <= DONE;
                    default: state_r <= IDLE;
                endcase
            end
        end
    end

    assign bus.o_uart_rd       = pop_s;
    assign bus.o_uart_wr       = uart_wr_r;
    assign bus.o_uart_wdata    = uart_wdata_r;
    assign bus.o_uart_tx_start = tx_start_r;
    assign bus.o_imem_wr_en    = imem_wr_en_r;
    assign bus.o_imem_addr     = imem_addr_r;
    assign bus.o_imem_wdata    = imem_wdata_r;
    assign bus.o_busy          = (state_r != IDLE) && (state_r != DONE);
    assign bus.o_load_done     = (state_r == DONE);

endmodule

// File: tb/tb_xmodem_imem_loader.sv
// Directed bench for the XMODEM instruction-memory loader.
module tb_xmodem_imem_loader;
    import xmodem_imem_loader_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    xmodem_imem_loader_if bus ();

    xmodem_imem_loader dut (
        .clk     (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    localparam logic [7:0] CKS_B = 8'hEB;   // 0x93+0xC0 + 124*0x1A mod 256

    int n_cmp = 0;
    int n_err = 0;

    logic [5:0]  wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [7:0]  tx_q[$];
    int          start_cnt = 0;
    int          order_err = 0;
    logic        wr_prev = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Record memory writes, transmitted bytes and transmit kicks away from the active edge.
    always @(negedge clk) begin
        if (bus.o_imem_wr_en === 1'b1) begin
            wr_addr_q.push_back(bus.o_imem_addr);
            wr_data_q.push_back(bus.o_imem_wdata);
        end
        if (bus.o_uart_wr === 1'b1) tx_q.push_back(bus.o_uart_wdata);
        if (bus.o_uart_tx_start === 1'b1) begin
            start_cnt++;
            if (wr_prev !== 1'b1) order_err++;
        end
        wr_prev = bus.o_uart_wr;
    end

    function automatic logic [7:0] payload(input int i);
        case (i)
            0:       return 8'h93;
            1:       return 8'h00;
            2:       return 8'hC0;
            3:       return 8'h00;
            default: return 8'h1A;
        endcase
    endfunction

    task automatic send_byte(input logic [7:0] b, input int max_cyc, output bit took);
        @(negedge clk);
        bus.i_uart_rx_data  = b;
        bus.i_uart_rx_empty = 1'b0;
        took = 1'b0;
        for (int i = 0; i < max_cyc && !took; i++) begin
            #1;
            if (bus.o_uart_rd === 1'b1) begin
                @(posedge clk);
                took = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        #1 bus.i_uart_rx_empty = 1'b1;
    endtask

    task automatic put(input logic [7:0] b);
        bit took;
        send_byte(b, 300, took);
        if (!took) check("rx_pop_timeout", 64'(took), 64'd1);
    endtask

    task automatic send_block(input logic [7:0] blk, input logic [7:0] blkn, input logic [7:0] cks);
        put(SOH);
        put(blk);
        put(blkn);
        for (int i = 0; i < 128; i++) put(payload(i));
        put(cks);
    endtask

    task automatic wait_resp();
        int s0;
        bit seen;
        s0 = start_cnt;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (start_cnt > s0) seen = 1'b1;
        end
        if (!seen) check("resp_timeout", 64'(seen), 64'd1);
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [63:0] outs();
        return 64'({bus.o_imem_wr_en, bus.o_imem_addr, bus.o_imem_wdata, bus.o_uart_wr,
                    bus.o_uart_wdata, bus.o_uart_tx_start, bus.o_busy, bus.o_load_done,
                    bus.o_uart_rd});
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1 check("reset_outputs", outs(), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    int mw, mt, ms, rd_seen;
    bit took;

    initial begin
        bus.i_en            = 1'b1;
        bus.i_uart_rx_data  = 8'h00;
        bus.i_uart_rx_empty = 1'b1;
        bus.i_uart_tx_full  = 1'b0;

        // Power-on reset
        #12 check("por_outputs", outs(), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Good block 1 with an i_en pause mid-block
        mw = wr_addr_q.size(); mt = tx_q.size(); ms = start_cnt;
        put(SOH); put(8'h01); put(8'hFE);
        check("busy_in_block", 64'(bus.o_busy), 64'd1);
        for (int i = 0; i < 128; i++) begin
            if (i == 10) begin
                @(negedge clk);
                bus.i_en = 1'b0;
                bus.i_uart_rx_data = payload(10);
                bus.i_uart_rx_empty = 1'b0;
                rd_seen = 0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    if (bus.o_uart_rd === 1'b1) rd_seen++;
                end
                check("en_low_no_pop", 64'(rd_seen), 64'd0);
                check("en_low_frozen_writes", 64'(wr_addr_q.size() - mw), 64'd2);
                bus.i_en = 1'b1;
                bus.i_uart_rx_empty = 1'b1;
            end
            put(payload(i));
        end
        put(CKS_B);
        wait_resp();
        check("good_wr_count", 64'(wr_addr_q.size() - mw), 64'd32);
        check("good_first_addr", 64'(wr_addr_q[mw]), 64'd0);
        check("good_first_data", 64'(wr_data_q[mw]), 64'h00C00093);
        check("good_last_addr", 64'(wr_addr_q[mw+31]), 64'd31);
        check("good_last_data", 64'(wr_data_q[mw+31]), 64'h1A1A1A1A);
        check("good_tx_count", 64'(tx_q.size() - mt), 64'd1);
        check("good_tx_ack", 64'(tx_q[tx_q.size()-1]), 64'h06);
        check("good_start_count", 64'(start_cnt - ms), 64'd1);
        check("good_idle_busy", 64'(bus.o_busy), 64'd0);

        // Bad checksum then correct resend
        do_reset();
        mw = wr_addr_q.size(); mt = tx_q.size();
        send_block(8'h01, 8'hFE, CKS_B + 8'd1);
        wait_resp();
        check("badck_nak", 64'(tx_q[tx_q.size()-1]), 64'h15);
        check("badck_wr_count", 64'(wr_addr_q.size() - mw), 64'd32);
        mw = wr_addr_q.size();
        send_block(8'h01, 8'hFE, CKS_B);
        wait_resp();
        check("resend_ack", 64'(tx_q[tx_q.size()-1]), 64'h06);
        check("resend_first_addr", 64'(wr_addr_q[mw]), 64'd0);
        check("resend_wr_count", 64'(wr_addr_q.size() - mw), 64'd32);

        // Duplicate block 1, then blocks 2 and 3 (address wrap)
        mw = wr_addr_q.size();
        send_block(8'h01, 8'hFE, CKS_B);
        wait_resp();
        check("dup_ack", 64'(tx_q[tx_q.size()-1]), 64'h06);
        check("dup_no_writes", 64'(wr_addr_q.size() - mw), 64'd0);
        send_block(8'h02, 8'hFD, CKS_B);
        wait_resp();
        check("blk2_ack", 64'(tx_q[tx_q.size()-1]), 64'h06);
        check("blk2_first_addr", 64'(wr_addr_q[mw]), 64'd32);
        check("blk2_first_data", 64'(wr_data_q[mw]), 64'h00C00093);
        check("blk2_last_addr", 64'(wr_addr_q[mw+31]), 64'd63);
        mw = wr_addr_q.size();
        send_block(8'h03, 8'hFC, CKS_B);
        wait_resp();
        check("blk3_ack", 64'(tx_q[tx_q.size()-1]), 64'h06);
        check("blk3_wrap_addr", 64'(wr_addr_q[mw]), 64'd0);
        check("blk3_wr_count", 64'(wr_addr_q.size() - mw), 64'd32);

        // Complement error
        do_reset();
        mw = wr_addr_q.size();
        send_block(8'h01, 8'hFD, CKS_B);
        wait_resp();
        check("cmpl_no_writes", 64'(wr_addr_q.size() - mw), 64'd0);
        check("cmpl_nak", 64'(tx_q[tx_q.size()-1]), 64'h15);

        // EOT after block 1
        do_reset();
        send_block(8'h01, 8'hFE, CKS_B);
        wait_resp();
        mt = tx_q.size();
        put(EOT);
        wait_resp();
        check("eot_ack", 64'(tx_q[tx_q.size()-1]), 64'h06);
        check("eot_done", 64'(bus.o_load_done), 64'd1);
        check("eot_busy", 64'(bus.o_busy), 64'd0);
        mw = wr_addr_q.size(); mt = tx_q.size();
        send_byte(SOH, 10, took);
        repeat (5) @(negedge clk);
        check("done_ignore_status", 64'({bus.o_load_done, bus.o_busy}), 64'b10);
        check("done_ignore_tx", 64'(tx_q.size() - mt), 64'd0);

        // TX FIFO full holds the response
        do_reset();
        bus.i_uart_tx_full = 1'b1;
        mt = tx_q.size();
        send_block(8'h01, 8'hFE, CKS_B);
        repeat (10) @(negedge clk);
        check("txfull_hold", 64'(tx_q.size() - mt), 64'd0);
        check("txfull_busy", 64'(bus.o_busy), 64'd1);
        bus.i_uart_tx_full = 1'b0;
        wait_resp();
        check("txfull_ack", 64'(tx_q.size() - mt), 64'd1);

        // Reset after the 50th data byte, then a good block 1
        do_reset();
        mw = wr_addr_q.size();
        put(SOH); put(8'h01); put(8'hFE);
        for (int i = 0; i < 50; i++) put(payload(i));
        check("mid_wr_count", 64'(wr_addr_q.size() - mw), 64'd12);
        @(negedge clk);
        rst_n = 1'b0;
        #1 check("mid_reset_outputs", outs(), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_no_more_writes", 64'(wr_addr_q.size() - mw), 64'd12);
        mw = wr_addr_q.size();
        send_block(8'h01, 8'hFE, CKS_B);
        wait_resp();
        check("after_rst_ack", 64'(tx_q[tx_q.size()-1]), 64'h06);
        check("after_rst_addr", 64'(wr_addr_q[mw]), 64'd0);
        check("after_rst_count", 64'(wr_addr_q.size() - mw), 64'd32);

        check("tx_start_after_wr", 64'(order_err), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/xmodem_imem_loader.md
XMODEM_IMEM_LOADER -- requirements
Module: xmodem_imem_loader

Interface
REQ-001 Parameter NB_UART_DATA, default 8, UART byte width.
REQ-002 Parameter NB_INSTRUCTION, default 32, instruction word width.
REQ-003 Parameter IMEM_ADDR_WIDTH, default 6, instruction-memory word-address width.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, with ports: clk in 1, rising-edge clock; i_rst_n in 1, asynchronous reset, active low.
REQ-005 i_en in 1: loader enable; when low, no byte is popped and the state is held.
REQ-006 i_uart_rx_data in NB_UART_DATA: head of the UART RX FIFO, valid while i_uart_rx_empty is low.
REQ-007 i_uart_rx_empty in 1: RX FIFO empty.
REQ-008 o_uart_rd out 1: one-cycle pop of the RX FIFO head.
REQ-009 i_uart_tx_full in 1: TX FIFO full.
REQ-010 o_uart_wr out 1, o_uart_wdata out NB_UART_DATA: TX FIFO write strobe and byte.
REQ-011 o_uart_tx_start out 1: one-cycle transmit kick.
REQ-012 o_imem_wr_en out 1, o_imem_addr out IMEM_ADDR_WIDTH, o_imem_wdata out NB_INSTRUCTION: instruction-memory write port.
REQ-013 o_busy out 1: a transfer is in progress. o_load_done out 1: level, set on end of transmission (EOT).

Function
REQ-014 States SHALL be IDLE, BLK, BLKN, DATA, CKSUM, RESP, DONE.
REQ-015 Byte consumption: a byte SHALL be consumed only when i_en=1 and i_uart_rx_empty=0; o_uart_rd pulses that same cycle; at most one byte per cycle.
REQ-016 IDLE transitions: on 0x01 (SOH) go to BLK; on 0x04 (EOT) queue ACK 0x06, then go to DONE after RESP; any other byte is discarded.
REQ-017 BLK: latch the block byte, then go to BLKN.
REQ-018 BLKN: latch the complement byte, then go to DATA with the byte counter at 0 and the checksum at 0.
REQ-019 Block classification:
- valid when blk^blkn==0xFF;
- new when blk == expected sequence (reset value 0x01);
- duplicate when blk == expected-1 (mod 256).
REQ-020 DATA: accept 128 bytes; checksum = 8-bit modulo-256 sum of the bytes; byte counter is 7 bits and wraps to 0 at the end of the block.
REQ-021 Word packing: bytes SHALL be packed little-endian (first byte goes to bits [7:0]).
REQ-022 Word write: o_imem_wr_en pulses for one cycle on each 4th byte, with that word on o_imem_wdata, only for a valid new block.
REQ-023 Word addressing: the first word of a new block goes to ((expected-1)*32) mod 2^IMEM_ADDR_WIDTH; o_imem_addr then increments by 1 per word and wraps modulo 2^IMEM_ADDR_WIDTH.
REQ-024 Duplicate or invalid blocks: no memory writes.
REQ-025 CKSUM: compare the received byte with the computed sum.
- ACK 0x06 if the block is valid, new or duplicate, and the checksum matches.
- Otherwise NAK 0x15.
- Expected sequence increments (mod 256) only on ACK of a new block.
REQ-026 NAK'd new block: the retransmitted block SHALL rewrite the same addresses.
REQ-027 RESP: wait while i_uart_tx_full=1; then one cycle with o_uart_wr=1 and o_uart_wdata=response; o_uart_tx_start=1 in the following cycle; then return to IDLE (or go to DONE after EOT).
REQ-028 DONE: set o_load_done=1, o_busy=0, and ignore further bytes until reset.
REQ-029 o_busy SHALL be 1 in every state except IDLE and DONE.
REQ-030 Simultaneous events: i_en falling mid-block freezes all counters; the transfer resumes when i_en returns to 1.

Reset
REQ-031 On i_rst_n=0, asynchronously:
- state = IDLE, expected sequence = 0x01, counters and checksum = 0;
- all outputs = 0.
REQ-032 Reset mid-block SHALL abandon the block with no further writes; already-written words are not erased.

Structure
REQ-033 A shared package SHALL hold SOH 0x01, EOT 0x04, ACK 0x06, NAK 0x15, BLOCK_BYTES 128 and the state encoding.
REQ-034 The design SHALL be a single module with no sub-modules; a registered FSM plus datapath registers.

Verification
REQ-035 Good block: SOH, 0x01, 0xFE, first word bytes 0x93,0x00,0xC0,0x00, then the rest of the block with 0x1A padding and the correct checksum -> first write to addr 0 with data 0x00C00093; ACK 0x06 transmitted once.
REQ-036 Bad checksum: block 1 with checksum+1 -> NAK 0x15; resend of the correct block -> same addresses rewritten, ACK, expected sequence = 2.
REQ-037 Complement error: SOH, 0x01, 0xFD -> no o_imem_wr_en pulse, NAK.
REQ-038 Duplicate and address wrap: block 1 ACKed, block 1 resent -> ACK, no writes; blocks 2 and 3 -> block 3 written starting at addr 0 (wrap), with IMEM_ADDR_WIDTH=6.
REQ-039 EOT: EOT after block 1 -> ACK 0x06, o_load_done=1, o_busy=0; a later SOH is ignored.
REQ-040 Mid-transfer disturbances:
- i_tx_full held for 10 cycles -> o_uart_wr delayed until full deasserts;
- i_rst_n pulsed after the 50th data byte -> all outputs 0 and state IDLE;
- a subsequent good block 1 is accepted.
